// File: rtl/pz_pkg.sv
// Shared types and default sizes for the pole/zero term sequencer.
// No logic lives here, so there is no latency of its own.
// Backpressure behaviour is not applicable.
package pz_pkg;

   // Sequencer control states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } pz_state_e;

   // Accumulator register stages; the sequencer keeps acc_ready up this many cycles
   localparam int PZ_PIPE_DEPTH    = 3;
   // Default number of term slots
   localparam int PZ_REG_FILE_SIZE = 8;
   // Default term and result width
   localparam int PZ_DATA_SIZE     = 8;

endpackage

// File: rtl/pz_term_regfile.sv
// Term slot storage: one write port, clear-all, every slot visible on a flat bus.
// Latency: a write or clear is visible on flat_o the cycle after the edge.
// Backpressure: none; the caller qualifies we_i/clr_i with its own handshake.
module pz_term_regfile #(
   parameter int N  = 8,
   parameter int W  = 8,
   parameter int AW = 3
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            we_i,
   input  logic [AW-1:0]   waddr_i,
   input  logic [W-1:0]    wdata_i,
   output logic [N*W-1:0]  flat_o
);

   logic [W-1:0] slot_q [N];

   // Slot array: clear wins over write, both gated by the caller's handshakes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N; i++) slot_q[i] <= '0;
      end else if (clr_i) begin
         for (int i = 0; i < N; i++) slot_q[i] <= '0;
      end else if (we_i) begin
         slot_q[waddr_i] <= wdata_i;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_flat
      assign flat_o[g*W +: W] = slot_q[g];
   end

endmodule

// File: rtl/pz_sequencer.sv
// Collects nz+np terms, runs the external accumulator pipeline, returns its result.
// Latency: result offered after edge nz+np+PIPE_DEPTH when terms arrive back to back.
// Backpressure: term gaps stall LOAD; DONE holds the result until res_ready.
module pz_sequencer
   import pz_pkg::*;
#(
   parameter int REG_FILE_SIZE = PZ_REG_FILE_SIZE,
   parameter int DATA_SIZE     = PZ_DATA_SIZE,
   parameter int PIPE_DEPTH    = PZ_PIPE_DEPTH
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic [3:0]                      cmd_nz,
   input  logic [3:0]                      cmd_np,
   input  logic                            term_valid,
   output logic                            term_ready,
   input  logic [DATA_SIZE-1:0]            term_data,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [DATA_SIZE-1:0]            res_data,
   output logic                            res_err,
   output logic [DATA_SIZE*REG_FILE_SIZE-1:0] acc_flat_pz,
   output logic [31:0]                     acc_no_z,
   output logic [31:0]                     acc_no_p,
   output logic                            acc_ready,
   input  logic [DATA_SIZE-1:0]            acc_pz,
   output logic                            busy
);

   localparam int AW = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1;

   pz_state_e   state_q, state_d;
   logic [3:0]  nz_q, nz_d;
   logic [3:0]  np_q, np_d;
   logic [4:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        rf_clr, rf_we;
   logic [4:0]  total, cmd_total;
   logic        cmd_fire, term_fire;

   assign total     = {1'b0, nz_q} + {1'b0, np_q};
   assign cmd_total = {1'b0, cmd_nz} + {1'b0, cmd_np};

   // Ready is held low while reset is applied so nothing looks acceptable then
   assign cmd_ready  = (state_q == ST_IDLE) && resetn;
   assign term_ready = (state_q == ST_LOAD);
   assign res_valid  = (state_q == ST_DONE);
   assign acc_ready  = (state_q == ST_RUN);
   assign busy       = (state_q != ST_IDLE);
   assign res_err    = (state_q == ST_DONE) && err_q;
   assign res_data   = (state_q == ST_DONE && !err_q) ? acc_pz : '0;
   assign acc_no_z   = 32'(nz_q);
   assign acc_no_p   = 32'(np_q);

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign term_fire = term_valid && term_ready;

   // Control registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         nz_q    <= '0;
         np_q    <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         nz_q    <= nz_d;
         np_q    <= np_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state: accept command, gather terms, count accumulator advances, hand off result
   always_comb begin
      state_d = state_q;
      nz_d    = nz_q;
      np_d    = np_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      rf_clr  = 1'b0;
      rf_we   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               rf_clr = 1'b1;
               idx_d  = '0;
               cnt_d  = '0;
               if (int'(cmd_total) > REG_FILE_SIZE) begin
                  // Oversized command: counts stay zero and the accumulator never runs
                  nz_d    = '0;
                  np_d    = '0;
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  nz_d    = cmd_nz;
                  np_d    = cmd_np;
                  err_d   = 1'b0;
                  state_d = (cmd_total == 5'd0) ? ST_RUN : ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            if (term_fire) begin
               rf_we = 1'b1;
               idx_d = idx_q + 5'd1;
               if (idx_q == total - 5'd1) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_q == 8'(PIPE_DEPTH - 1)) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   pz_term_regfile #(
      .N  (REG_FILE_SIZE),
      .W  (DATA_SIZE),
      .AW (AW)
   ) u_regfile (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .clr_i   (rf_clr),
      .we_i    (rf_we),
      .waddr_i (idx_q[AW-1:0]),
      .wdata_i (term_data),
      .flat_o  (acc_flat_pz)
   );

endmodule

// File: tb/tb_pz_sequencer.sv
module tb_pz_sequencer;

   localparam int RF = 8;
   localparam int DW = 8;
   localparam int PD = 3;

   logic           clk = 1'b0;
   logic           resetn;
   logic           cmd_valid, cmd_ready;
   logic [3:0]     cmd_nz, cmd_np;
   logic           term_valid, term_ready;
   logic [DW-1:0]  term_data;
   logic           res_valid, res_ready;
   logic [DW-1:0]  res_data;
   logic           res_err;
   logic [DW*RF-1:0] acc_flat_pz;
   logic [31:0]    acc_no_z, acc_no_p;
   logic           acc_ready;
   logic [DW-1:0]  acc_pz;
   logic           busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] tq[$];
   logic [DW-1:0] acc_pipe [PD];

   always #5 clk = ~clk;

   pz_sequencer #(.REG_FILE_SIZE(RF), .DATA_SIZE(DW), .PIPE_DEPTH(PD)) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_nz(cmd_nz), .cmd_np(cmd_np),
      .term_valid(term_valid), .term_ready(term_ready), .term_data(term_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
      .acc_flat_pz(acc_flat_pz), .acc_no_z(acc_no_z), .acc_no_p(acc_no_p),
      .acc_ready(acc_ready), .acc_pz(acc_pz), .busy(busy)
   );

   // External accumulator stand-in: signed sum of the term bus, PD stages, advanced by acc_ready
   function automatic logic [DW-1:0] acc_sum();
      int s = 0;
      for (int i = 0; i < RF; i++) begin
         if (i < int'(acc_no_z)) s += int'(acc_flat_pz[i*DW +: DW]);
         else if (i < int'(acc_no_z + acc_no_p)) s -= int'(acc_flat_pz[i*DW +: DW]);
      end
      return DW'(s);
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < PD; i++) acc_pipe[i] <= '0;
      end else if (acc_ready) begin
         acc_pipe[0] <= acc_sum();
         for (int i = 1; i < PD; i++) acc_pipe[i] <= acc_pipe[i-1];
      end
   end
   assign acc_pz = acc_pipe[PD-1];

   // Expected result straight from the term list
   function automatic logic [7:0] ref_result(input int nz, input int np);
      int s = 0;
      for (int i = 0; i < nz + np; i++) s += (i < nz) ? int'(tq[i]) : -int'(tq[i]);
      return 8'(s);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full command: offer, feed terms with random gaps, check result, hold, consume
   task automatic do_cmd(input int nz, input int np, input int gap_pct, input int hold);
      int n, ecnt, k, fires, acc_cnt, last_fire, exp_edge;
      bit err, tr_seen, tv, fire;
      logic [7:0] exp_res, held;
      n = nz + np;
      err = (n > RF);
      exp_res = err ? 8'h00 : ref_result(nz, np);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1; cmd_nz = 4'(nz); cmd_np = 4'(np);
      @(posedge clk); #1;
      ecnt = 0; k = 0; fires = 0; acc_cnt = 0; last_fire = 0; tr_seen = 0;
      while (res_valid !== 1'b1 && ecnt < 100) begin
         if (term_ready === 1'b1) tr_seen = 1;
         if (acc_ready === 1'b1) acc_cnt++;
         tv = (k < n) ? ($urandom_range(0, 99) >= gap_pct) : 1'($urandom_range(0, 1));
         term_valid = tv;
         term_data  = (k < n) ? tq[k] : 8'($urandom);
         fire = tv && (term_ready === 1'b1);
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_nz = 4'($urandom); cmd_np = 4'($urandom);
         res_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         ecnt++;
         if (fire) begin k++; fires++; last_fire = ecnt; end
      end
      term_valid = 0; cmd_valid = 0; res_ready = 0;
      exp_edge = err ? 0 : ((n == 0) ? PD : last_fire + PD);
      chk("res_valid_rise", res_valid, 1);
      chk("latency_edges", ecnt, exp_edge);
      chk("term_fires", fires, err ? 0 : n);
      chk("acc_ready_cycles", acc_cnt, err ? 0 : PD);
      chk("term_ready_seen", tr_seen, (!err && n > 0));
      chk("res_err", res_err, err);
      chk("res_data", res_data, exp_res);
      chk("acc_no_z", acc_no_z, err ? 0 : nz);
      chk("acc_no_p", acc_no_p, err ? 0 : np);
      if (err) chk("acc_flat_cleared", acc_flat_pz, 0);
      chk("cmd_ready_done", cmd_ready, 0);
      held = res_data;
      for (int h = 0; h < hold; h++) begin
         cmd_valid = 1; cmd_nz = 4'd1; cmd_np = 4'd0;
         @(posedge clk); #1;
         chk("hold_res_valid", res_valid, 1);
         chk("hold_res_data", res_data, held);
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      // Result fire with a command also offered: the command must not be taken
      res_ready = 1; cmd_valid = 1; cmd_nz = 4'd1; cmd_np = 4'd0;
      @(posedge clk); #1;
      res_ready = 0; cmd_valid = 0;
      chk("after_fire_res_valid", res_valid, 0);
      chk("after_fire_busy", busy, 0);
      chk("after_fire_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      int nz, np, wd;
      resetn = 0; cmd_valid = 0; cmd_nz = 0; cmd_np = 0;
      term_valid = 0; term_data = 0; res_ready = 0;
      #3;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_acc_ready", acc_ready, 0);
      chk("rst_term_ready", term_ready, 0);
      chk("rst_flat", acc_flat_pz, 0);
      chk("rst_no_z", acc_no_z, 0);
      @(negedge clk); resetn = 1;
      @(posedge clk); #1;
      chk("post_rst_cmd_ready", cmd_ready, 1);

      // nz=2 np=1 terms 10,20,5 -> 25 after edge 6
      tq = '{8'd10, 8'd20, 8'd5};
      do_cmd(2, 1, 0, 0);
      // empty command
      tq = {};
      do_cmd(0, 0, 0, 0);
      // oversized command rejected
      do_cmd(5, 4, 0, 0);
      // wrap-around both directions
      tq = {};
      for (int i = 0; i < 8; i++) tq.push_back(8'h40);
      do_cmd(8, 0, 0, 0);
      tq = '{8'h01};
      do_cmd(0, 1, 0, 0);
      // gaps plus a 5-cycle held result
      tq = {};
      for (int i = 0; i < 6; i++) tq.push_back(8'($urandom));
      do_cmd(3, 3, 40, 5);
      // random commands, occasionally oversized
      for (int t = 0; t < 20; t++) begin
         nz = $urandom_range(0, 8);
         np = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8 - nz);
         tq = {};
         for (int i = 0; i < nz + np; i++) tq.push_back(8'($urandom));
         do_cmd(nz, np, $urandom_range(0, 60), $urandom_range(0, 5));
      end

      // reset in the 2nd RUN cycle aborts the command
      cmd_valid = 1; cmd_nz = 4'd2; cmd_np = 4'd1;
      @(posedge clk); #1;
      cmd_valid = 0; term_valid = 1; term_data = 8'd9;
      wd = 0;
      while (acc_ready !== 1'b1 && wd < 50) begin
         @(posedge clk); #1;
         wd++;
      end
      term_valid = 0;
      chk("rst_test_run_reached", acc_ready, 1);
      @(posedge clk); #1;
      resetn = 0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_acc_ready", acc_ready, 0);
      chk("abort_res_valid", res_valid, 0);
      chk("abort_res_data", res_data, 0);
      chk("abort_flat", acc_flat_pz, 0);
      chk("abort_no_z", acc_no_z, 0);
      @(negedge clk); resetn = 1;
      @(posedge clk); #1;
      tq = '{8'd7};
      do_cmd(1, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
